rvv_vrf_mp: RTL

- Parametrised multi-port vector register file; next generation of the single-write-vector VRF register array.
- Provides NWR byte-enabled write ports with fixed priority and NRD registered read ports with optional write-to-read bypass.
- Adds a sequential bulk-clear engine that zeroes the file one register per cycle.
- Sits between the RVV dispatch/retire logic (writers) and the vector execution units (readers).

---
 rtl/rvv_vrf_mp_if.sv | 32 +++
 rtl/rvv_vrf_mp.sv | 118 +++++++++++
 2 files changed

// File: rtl/rvv_vrf_mp_if.sv
// rvv_vrf_mp_if: bundle of write/read/clear signals between VRF clients and the register file
//   master: drives wr_* / rd_valid / rd_addr / clr_req, receives rd_data / rd_data_valid / clr_* / wr_conflict
//   slave : the register file side
interface rvv_vrf_mp_if #(
    parameter int NREG = 32,
    parameter int VLEN = 128,
    parameter int NWR  = 2,
    parameter int NRD  = 3
);
    localparam int AW    = $clog2(NREG);
    localparam int VLENB = VLEN / 8;
    logic [NWR-1:0]       wr_valid;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*VLENB-1:0] wr_be;
    logic [NWR*VLEN-1:0]  wr_data;
    logic [NRD-1:0]       rd_valid;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*VLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_data_valid;
    logic                 clr_req;
    logic                 clr_busy;
    logic                 clr_done;
    logic                 wr_conflict;
    modport master (
        output wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr, clr_req,
        input  rd_data, rd_data_valid, clr_busy, clr_done, wr_conflict
    );
    modport slave (
        input  wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr, clr_req,
        output rd_data, rd_data_valid, clr_busy, clr_done, wr_conflict
    );
endinterface

// File: rtl/rvv_vrf_mp.sv
// rvv_vrf_mp: multi-port vector register file with byte-enabled prioritised writes, registered reads and bulk clear
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : rvv_vrf_mp_if.slave (write ports, read ports, clear control, conflict flag)
module rvv_vrf_mp #(
    parameter int NREG   = 32,
    parameter int VLEN   = 128,
    parameter int NWR    = 2,
    parameter int NRD    = 3,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst_n,
    rvv_vrf_mp_if.slave bus
);
    localparam int AW    = $clog2(NREG);
    localparam int VLENB = VLEN / 8;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

    state_e              state_q;
    logic [AW-1:0]       idx_q;
    logic                clr_busy_q, clr_done_q;
    logic                wr_conflict_q, wr_conflict_d;
    logic [VLEN-1:0]     mem_q [NREG];
    logic [VLEN-1:0]     mem_d [NREG];
    logic [NRD*VLEN-1:0] rd_data_q, rd_data_d;
    logic [NRD-1:0]      rd_data_valid_q;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREG);
    endfunction

    // Ports applied in ascending order so the highest-indexed writer wins each byte;
    // the clear is applied last so it overrides any write to reg idx.
    always_comb begin
        mem_d = mem_q;
        wr_conflict_d = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (bus.wr_valid[p] && in_range(bus.wr_addr[p*AW +: AW])) begin
                for (int b = 0; b < VLENB; b++)
                    if (bus.wr_be[p*VLENB+b])
                        mem_d[bus.wr_addr[p*AW +: AW]][b*8 +: 8] = bus.wr_data[p*VLEN+b*8 +: 8];
                for (int o = p + 1; o < NWR; o++)
                    if (bus.wr_valid[o] && bus.wr_addr[o*AW +: AW] == bus.wr_addr[p*AW +: AW] &&
                        |(bus.wr_be[o*VLENB +: VLENB] & bus.wr_be[p*VLENB +: VLENB]))
                        wr_conflict_d = 1'b1;
            end
        end
        if (state_q == CLEAR)
            mem_d[idx_q] = '0;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        for (int q = 0; q < NRD; q++)
            if (bus.rd_valid[q])
                rd_data_d[q*VLEN +: VLEN] = !in_range(bus.rd_addr[q*AW +: AW]) ? '0 :
                                            BYPASS != 0 ? mem_d[bus.rd_addr[q*AW +: AW]] :
                                                          mem_q[bus.rd_addr[q*AW +: AW]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q           <= '{default: '0};
            rd_data_q       <= '0;
            rd_data_valid_q <= '0;
            wr_conflict_q   <= 1'b0;
        end else begin
            mem_q           <= mem_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= bus.rd_valid;
            wr_conflict_q   <= wr_conflict_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.clr_req) begin
                    state_q    <= CLEAR;
                    idx_q      <= '0;
                    clr_busy_q <= 1'b1;
                end
                CLEAR: if (idx_q == AW'(NREG - 1)) begin
                    state_q    <= DONE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + AW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.clr_busy      = clr_busy_q;
    assign bus.clr_done      = clr_done_q;
    assign bus.wr_conflict   = wr_conflict_q;

`ifdef ASSERT_ON
    assert property (@(posedge clk) disable iff (!rst_n) !(clr_done_q && clr_busy_q));
    for (genvar p = 0; p < NWR; p++) begin : g_ax_p
        for (genvar b = 0; b < VLENB; b++) begin : g_ax_b
            assert property (@(posedge clk) disable iff (!rst_n)
                bus.wr_valid[p] && bus.wr_be[p*VLENB+b] |-> !$isunknown(bus.wr_data[p*VLEN+b*8 +: 8]));
        end
    end
`endif
endmodule
